// File: rtl/start_sequencer.sv
// start_sequencer: debounced push-button launcher for a downstream fsm with completion timeout and run counter
module start_sequencer #(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       flag_done,
  input  logic       clr_err,
  output logic       start,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] run_cnt
);
  typedef enum logic [1:0] {IDLE, FIRE, WAIT, ERR} state_t;
  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [1:0]  sync_q;
  logic        deb, deb_d, deb_rise;
  logic [7:0]  deb_cnt;
  logic [15:0] tcnt;
  // two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], btn_in};
  // debounce: adopt the synchronized level after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_q[1] == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb     <= sync_q[1];
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 8'd1;
    end
  // registered one-cycle pulse on each debounced rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deb_d    <= 1'b0;
      deb_rise <= 1'b0;
    end else begin
      deb_d    <= deb;
      deb_rise <= deb & ~deb_d;
    end
  // run control fsm with registered outputs; rises outside IDLE are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      start       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      run_cnt     <= '0;
      tcnt        <= '0;
    end else begin
      case (state)
        IDLE: if (deb_rise) begin
          state <= FIRE;
          start <= 1'b1;
          busy  <= 1'b1;
        end
        FIRE: begin
          state <= WAIT;
          start <= 1'b0;
          tcnt  <= '0;
        end
        WAIT: if (flag_done) begin
          state   <= IDLE;
          busy    <= 1'b0;
          run_cnt <= run_cnt + 8'd1;
        end else if (tcnt == TO_LAST) begin
          state       <= ERR;
          busy        <= 1'b0;
          timeout_err <= 1'b1;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
        ERR: if (clr_err) begin
          state       <= IDLE;
          timeout_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_start_sequencer.sv
// tb_start_sequencer: scoreboard bench checking start timing, run counting, timeout and reset behaviour
module tb_start_sequencer;
  localparam int DEB = 4;
  localparam int TO  = 16;
  logic       clk = 1'b0;
  logic       rst_n, btn_in, flag_done, clr_err;
  logic       start, busy, timeout_err;
  logic [7:0] run_cnt;
  logic [7:0] exp_cnt;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];

  start_sequencer #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .flag_done(flag_done), .clr_err(clr_err),
    .start(start), .busy(busy), .timeout_err(timeout_err), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every observed start pulse must match the next predicted cycle
  always @(negedge clk)
    if (start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected cyc=%0d got start=1 expected none", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL start_latency got cyc=%0d expected cyc=%0d", cyc, e);
        end
      end
    end

  // called at a negedge: the next posedge is the first to sample btn high
  task automatic press();
    btn_in = 1'b1;
    exp_q.push_back(cyc + 1 + DEB + 3);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_start got no start within 30 cycles expected a pulse");
  endtask

  task automatic release_btn();
    btn_in = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic do_run(input int dly);
    press();
    wait_start();
    repeat (dly) @(negedge clk);
    flag_done = 1'b1;
    @(negedge clk);
    flag_done = 1'b0;
    exp_cnt++;
    release_btn();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_in = 1'b0; flag_done = 1'b0; clr_err = 1'b0; exp_cnt = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({start, busy, timeout_err, run_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b/%b/%0d expected 0/0/0/0", start, busy, timeout_err, run_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    btn_in = 1'b1;
    repeat (DEB - 1) @(negedge clk);
    btn_in = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy got busy=1 expected 0");
    end
  endtask

  task automatic test_normal();
    int nb;
    press();
    wait_start();
    nb = int'(busy);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      nb += int'(busy);
      if (i == 5) flag_done = 1'b1;
    end
    @(negedge clk);
    flag_done = 1'b0;
    exp_cnt++;
    nb += int'(busy);
    checks++;
    if (nb !== 6) begin
      errors++;
      $display("FAIL normal_busy_len got %0d expected 6", nb);
    end
    checks++;
    if (run_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL normal_run_cnt got %0d expected %0d", run_cnt, exp_cnt);
    end
    repeat (20) @(negedge clk);
    release_btn();
  endtask

  task automatic test_timeout();
    press();
    wait_start();
    repeat (TO) @(negedge clk);
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_early got err=%b busy=%b expected err=0 busy=1", timeout_err, busy);
    end
    @(negedge clk);
    checks++;
    if ({timeout_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_set got err=%b busy=%b expected err=1 busy=0", timeout_err, busy);
    end
    release_btn();
    flag_done = 1'b1;
    @(negedge clk);
    flag_done = 1'b0;
    btn_in = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if ({timeout_err, run_cnt} !== {1'b1, exp_cnt}) begin
      errors++;
      $display("FAIL timeout_hold got err=%b cnt=%0d expected err=1 cnt=%0d", timeout_err, run_cnt, exp_cnt);
    end
    release_btn();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if ({timeout_err, run_cnt} !== {1'b0, exp_cnt}) begin
      errors++;
      $display("FAIL timeout_clear got err=%b cnt=%0d expected err=0 cnt=%0d", timeout_err, run_cnt, exp_cnt);
    end
  endtask

  task automatic test_simultaneous();
    press();
    wait_start();
    repeat (TO) @(negedge clk);
    flag_done = 1'b1;
    @(negedge clk);
    flag_done = 1'b0;
    exp_cnt++;
    checks++;
    if ({timeout_err, busy, run_cnt} !== {2'b00, exp_cnt}) begin
      errors++;
      $display("FAIL simultaneous got err=%b busy=%b cnt=%0d expected 0/0/%0d", timeout_err, busy, run_cnt, exp_cnt);
    end
    release_btn();
  endtask

  task automatic test_reset_midrun();
    press();
    wait_start();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    checks++;
    if ({start, busy, timeout_err, run_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async got %b/%b/%b/%0d expected 0/0/0/0", start, busy, timeout_err, run_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(cyc + 1 + DEB + 3);
    wait_start();
    @(negedge clk);
    flag_done = 1'b1;
    @(negedge clk);
    flag_done = 1'b0;
    exp_cnt++;
    checks++;
    if (run_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL reset_repress_cnt got %0d expected %0d", run_cnt, exp_cnt);
    end
    release_btn();
  endtask

  task automatic test_wrap();
    while (exp_cnt != 8'd255) do_run(1);
    checks++;
    if (run_cnt !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255 got %0d expected 255", run_cnt);
    end
    do_run(2);
    checks++;
    if (run_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0 got %0d expected 0", run_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_normal();
    test_timeout();
    test_simultaneous();
    test_reset_midrun();
    test_wrap();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_starts got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
